oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

OAM DMA controller and memory-bus arbiter between the CPU and the shared system bus. A CPU write to register 0xFF46 starts a 160-byte copy from (value<<8) to OAM at 0xFE00. While the copy runs, the block owns the bus, filters CPU accesses and stalls the CPU when it must. It sits between the datapath's memory port and the memory/MMIO decoder in `top`, clocked by `cpu_clk`.

## Interface
- `DMA_LEN`, 160: bytes per transfer.
- `CLKS_PER_BYTE`, 4: clocks per byte slot (one M-cycle); must be ≥4.
- `DST_BASE`, 16'hFE00: OAM destination base.
- `DMA_REG_ADDR`, 16'hFF46: DMA source register address.
- `cpu_clk` in 1: the block's only clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_re`, `cpu_we` in 1 each: CPU read/write strobes; at most one high per cycle.
- `cpu_rdata` out 8: CPU read data, valid the cycle after `cpu_re`.
- `cpu_wait` out 1: stall; the CPU holds its request and retries next cycle.
- `mem_addr` out 16, `mem_wdata` out 8, `mem_re` out 1, `mem_we` out 1: system bus.
- `mem_rdata` in 8: bus read data, 1-cycle latency after `mem_re`.
- `dma_active` out 1: high from the start-delay slot to the last write.

## Operation
- States: IDLE, START, XFER. A phase counter 0..CLKS_PER_BYTE-1 and a byte index 0..DMA_LEN-1.
- Register write: `cpu_we` to DMA_REG_ADDR in any state, without stall:
  - latches `src_hi` = `cpu_wdata`; if `cpu_wdata` ≥ 0xE0, bit 5 is cleared (E0–FF maps to C0–DF);
  - sets index=0, phase=0, state=START.
- This register access never reaches the bus.
- Register read: returns the raw last-written value (reset value 0xFF).
- START: one full CLKS_PER_BYTE slot with no DMA bus use, then XFER.
- XFER slot, per phase:
  - phase 0: `mem_re`=1, `mem_addr`={src_hi, index[7:0]};
  - phase 1: capture `mem_rdata` into a byte buffer;
  - phase 2: `mem_we`=1, `mem_addr`=DST_BASE+index, `mem_wdata`=buffer;
  - phase 3+: bus free.
- At the end of the slot, index increments. After index DMA_LEN-1 completes, state returns to IDLE and `dma_active` drops on the following cycle.
- CPU arbitration, IDLE: `mem_*` = CPU signals combinationally; `cpu_rdata` = `mem_rdata`; `cpu_wait`=0.
- CPU arbitration, START/XFER:
  - In a DMA-owned phase (XFER phase 0 or 2), any pass-through CPU access sees `cpu_wait`=1 and does not reach the bus.
  - In other phases the access passes as in IDLE, subject to Configuration filtering.
- A blocked CPU read returns 0xFF the next cycle. A blocked write is dropped. Neither issues a bus strobe.
- The `cpu_rdata` mux select is registered alongside the request: pass-through, register value, or 0xFF.

## Timing
- Reset values: state IDLE, `dma_active`=0, `mem_re`=`mem_we`=0, `cpu_wait`=0, `src_hi`=0xFF, `cpu_rdata`=0xFF until the first read.
- Transfer length: START plus DMA_LEN slots = (DMA_LEN+1)·CLKS_PER_BYTE = 644 clocks by default.
- Write to OAM byte i occurs at clock CLKS_PER_BYTE·(i+1)+2 after the register write.
- `dma_active` rises the cycle after the register write.
- Restart mid-transfer: a register write in START or XFER aborts the current slot, including a pending phase-2 write. The new START begins the next cycle.
- Register write coinciding with the final slot's phase 2: the restart wins and that final write is dropped.
- Reset mid-transfer: all DMA strobes are low from the next cycle and no further OAM write occurs.

## Configuration
- `OAM_DMA_BUS_LOCK_EN` defined:
  - during START/XFER, CPU accesses outside HRAM (0xFF80–0xFFFE) and DMA_REG_ADDR are blocked (read 0xFF, write dropped);
  - HRAM accesses pass in free phases and stall in DMA-owned phases.
- Undefined: no address filtering. All CPU accesses pass in free phases and stall in DMA-owned phases.

## Test plan
- Reset bus-idle check, IDLE pass-through: after `rst`, `mem_re`=`mem_we`=0 and `dma_active`=0. Then write 0x5A to 0xC000 and read it back: 0x5A appears on `cpu_rdata` one cycle after `cpu_re`.
- Basic transfer: RAM C100+i = i; write 0xC1 to 0xFF46. Expect `dma_active` high 644 clocks and OAM FE00+i = i for i=0..159. The first `mem_we` is at clock 6; reading 0xFF46 returns 0xC1.
- Lock: with OAM_DMA_BUS_LOCK_EN, during XFER read 0x8000 and write 0xAA to 0xC000. Expect `cpu_rdata`=0xFF, RAM unchanged, and no CPU-sourced strobe.
- Arbitration: HRAM write 0x33 to 0xFF80 issued at phase 0 gets `cpu_wait`=1 for one cycle. It passes at phase 1 and 0xFF80 reads 0x33.
- Restart and echo clamp: at byte 50, write 0xE2 to 0xFF46. Source switches to C200; OAM FE00–FE9F ends equal to C200–C29F. The total from restart is 644 clocks; reading 0xFF46 returns 0xE2.
- Reset mid-transfer: assert `rst` at byte 80. No `mem_we` occurs from the next cycle, `dma_active`=0, and OAM bytes ≥80 are untouched.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA engine and CPU/DMA arbiter for the shared system bus.
// A CPU write to DMA_REG_ADDR starts a DMA_LEN-byte copy from {src_hi, idx}
// to DST_BASE + idx. Each byte uses one CLKS_PER_BYTE slot: read in phase 0,
// capture in phase 1, write in phase 2. Later phases leave the bus free.
// Optional feature macro: OAM_DMA_BUS_LOCK_EN. When it is defined, CPU
// accesses outside HRAM are blocked while a transfer is in progress.
module oam_dma_ctrl #(
  parameter int          DMA_LEN       = 160,
  parameter int          CLKS_PER_BYTE = 4,
  parameter logic [15:0] DST_BASE      = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR  = 16'hFF46
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam int             PW       = (CLKS_PER_BYTE > 1) ? $clog2(CLKS_PER_BYTE) : 1;
  localparam logic [PW-1:0]  PH_LAST  = PW'(CLKS_PER_BYTE - 1);
  localparam logic [PW-1:0]  PH_READ  = PW'(0);
  localparam logic [PW-1:0]  PH_CAPT  = PW'(1);
  localparam logic [PW-1:0]  PH_WRITE = PW'(2);
  localparam logic [7:0]     IDX_LAST = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  // Source of cpu_rdata for the cycle after a CPU read.
  typedef enum logic [1:0] {
    RD_FF  = 2'd0,
    RD_BUS = 2'd1,
    RD_REG = 2'd2
  } rsel_t;

  state_t        state_q, state_d;
  rsel_t         rsel_q, rsel_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    index_q, index_d;
  logic [7:0]    src_hi_q, src_hi_d;   // clamped source page used on the bus
  logic [7:0]    src_raw_q, src_raw_d; // value the CPU wrote, for readback
  logic [7:0]    buf_q, buf_d;         // byte in flight between read and write

  logic reg_hit;
  logic reg_wr;
  logic busy;
  logic dma_owned;
  logic lock_block;
  logic cpu_pass;
  logic cpu_bus;
  logic dma_rd;
  logic dma_wr;

  // The DMA register is decoded out of the bus entirely and never stalls.
  assign reg_hit   = (cpu_addr == DMA_REG_ADDR);
  assign reg_wr    = cpu_we && reg_hit;
  assign busy      = (state_q != S_IDLE);
  assign dma_owned = (state_q == S_XFER) && ((phase_q == PH_READ) || (phase_q == PH_WRITE));

`ifdef OAM_DMA_BUS_LOCK_EN
  logic hram_hit;
  assign hram_hit   = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign lock_block = busy && !hram_hit && !reg_hit;
`else
  assign lock_block = 1'b0;
`endif

  // A pass-through access either reaches the bus or is stalled by the DMA.
  assign cpu_pass = (cpu_re || cpu_we) && !reg_hit && !lock_block;
  assign cpu_wait = cpu_pass && dma_owned;
  assign cpu_bus  = cpu_pass && !dma_owned;

  // A register write in the same cycle aborts the slot, so it also kills
  // that cycle's DMA strobe (including the last byte's phase-2 write).
  assign dma_rd = (state_q == S_XFER) && (phase_q == PH_READ) && !reg_wr;
  assign dma_wr = (state_q == S_XFER) && (phase_q == PH_WRITE) && !reg_wr;

  assign dma_active = busy;

  // State register and transfer bookkeeping.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rsel_q    <= RD_FF;
      phase_q   <= '0;
      index_q   <= '0;
      src_hi_q  <= 8'hFF;
      src_raw_q <= 8'hFF;
      buf_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      rsel_q    <= rsel_d;
      phase_q   <= phase_d;
      index_q   <= index_d;
      src_hi_q  <= src_hi_d;
      src_raw_q <= src_raw_d;
      buf_q     <= buf_d;
    end
  end

  // Next-state logic: register writes restart from any state, otherwise
  // walk the phase counter through START and then each XFER slot.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    index_d   = index_q;
    src_hi_d  = src_hi_q;
    src_raw_d = src_raw_q;
    buf_d     = buf_q;
    if (reg_wr) begin
      src_raw_d = cpu_wdata;
      // Echo RAM pages E0-FF fold back onto C0-DF.
      src_hi_d  = (cpu_wdata >= 8'hE0) ? (cpu_wdata & 8'hDF) : cpu_wdata;
      index_d   = '0;
      phase_d   = '0;
      state_d   = S_START;
    end else begin
      case (state_q)
        S_START: begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            state_d = S_XFER;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_XFER: begin
          if (phase_q == PH_CAPT) begin
            buf_d = mem_rdata;
          end
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (index_q == IDX_LAST) begin
              index_d = '0;
              state_d = S_IDLE;
            end else begin
              index_d = index_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: begin
          phase_d = '0;
        end
      endcase
    end
  end

  // Read-data select is captured with each CPU read and held until the next.
  always_comb begin
    rsel_d = rsel_q;
    if (cpu_re) begin
      if (reg_hit) begin
        rsel_d = RD_REG;
      end else if (lock_block || dma_owned) begin
        rsel_d = RD_FF;
      end else begin
        rsel_d = RD_BUS;
      end
    end
  end

  // CPU read data mux.
  always_comb begin
    case (rsel_q)
      RD_BUS:  cpu_rdata = mem_rdata;
      RD_REG:  cpu_rdata = src_raw_q;
      default: cpu_rdata = 8'hFF;
    endcase
  end

  // System bus mux: DMA strobes take priority, then a permitted CPU access.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (dma_rd) begin
      mem_re   = 1'b1;
      mem_addr = {src_hi_q, index_q};
    end else if (dma_wr) begin
      mem_we    = 1'b1;
      mem_addr  = DST_BASE + {8'h00, index_q};
      mem_wdata = buf_q;
    end else if (cpu_bus) begin
      mem_re = cpu_re;
      mem_we = cpu_we;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed testbench for oam_dma_ctrl with a 64 KiB bus memory model.
// Cycle numbering in transfer tests: cycle 0 is the first cycle after the
// register write edge (first cycle with dma_active high).
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_BUS_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_re;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .cpu_clk    (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .cpu_wait   (cpu_wait),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  // Bus memory: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, output int waits);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    #1;
    waits = 0;
    while (cpu_wait && waits < 16) begin
      @(negedge clk); #1; waits++;
    end
    checks++;
    if (waits >= 16) begin
      fails++;
      $display("FAIL cpu_wr_stall_timeout: addr %h stalled %0d cycles, limit 15", a, waits);
    end
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d, output int waits);
    @(negedge clk);
    cpu_addr = a; cpu_re = 1'b1;
    #1;
    waits = 0;
    while (cpu_wait && waits < 16) begin
      @(negedge clk); #1; waits++;
    end
    checks++;
    if (waits >= 16) begin
      fails++;
      $display("FAIL cpu_rd_stall_timeout: addr %h stalled %0d cycles, limit 15", a, waits);
    end
    @(negedge clk);
    cpu_re = 1'b0;
    #1;
    d = cpu_rdata;
  endtask

  // Follows a transfer from cycle 0 until dma_active drops (bounded).
  task automatic run_to_idle(output int act, output int first_we, output logic [15:0] first_addr,
                             output int n_we);
    act = 0; first_we = -1; n_we = 0; first_addr = 16'h0000;
    for (int k = 0; k < 3000; k++) begin
      #1;
      if (!dma_active) break;
      act++;
      if (mem_we) begin
        n_we++;
        if (first_we < 0) begin
          first_we = k;
          first_addr = mem_addr;
        end
      end
      @(negedge clk);
    end
    $display("transfer: active %0d cycles, first write cycle %0d at %h, %0d writes",
             act, first_we, first_addr, n_we);
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_re = 1'b0; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: re/we %b%b, required 00", mem_re, mem_we);
    end
    checks++;
    if (dma_active !== 1'b0) begin
      fails++; $display("FAIL reset_dma_active: got %b, required 0", dma_active);
    end
    checks++;
    if (cpu_wait !== 1'b0) begin
      fails++; $display("FAIL reset_cpu_wait: got %b, required 0", cpu_wait);
    end
    checks++;
    if (cpu_rdata !== 8'hFF) begin
      fails++; $display("FAIL reset_cpu_rdata: got %h, required ff", cpu_rdata);
    end
    $display("reset: strobes %b%b active %b rdata %h", mem_re, mem_we, dma_active, cpu_rdata);
  endtask

  task automatic test_idle_regs();
    logic [7:0] d;
    int w;
    cpu_rd(16'hFF46, d, w);
    checks++;
    if (d !== 8'hFF) begin
      fails++; $display("FAIL reg_reset_value: read %h, required ff", d);
    end
    $display("read ff46 after reset: %h", d);
  endtask

  task automatic test_passthru();
    logic [7:0] d;
    int w;
    cpu_wr(16'hC000, 8'h5A, w);
    checks++;
    if (mem[16'hC000] !== 8'h5A) begin
      fails++; $display("FAIL idle_write: mem[c000] %h, required 5a", mem[16'hC000]);
    end
    cpu_rd(16'hC000, d, w);
    checks++;
    if (d !== 8'h5A) begin
      fails++; $display("FAIL idle_read: cpu_rdata %h, required 5a", d);
    end
    $display("idle pass-through: wrote 5a to c000, read %h", d);
  endtask

  task automatic test_basic();
    int act, fw, nw, bad, w;
    logic [15:0] fa;
    logic [7:0] d;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC100 + i] = 8'(i);
      mem[16'hFE00 + i] = 8'hEE;
    end
    cpu_wr(16'hFF46, 8'hC1, w);
    run_to_idle(act, fw, fa, nw);
    checks++;
    if (act !== 644) begin
      fails++; $display("FAIL basic_active_len: %0d cycles, required 644", act);
    end
    checks++;
    if (fw !== 6) begin
      fails++; $display("FAIL basic_first_we_cycle: cycle %0d, required 6", fw);
    end
    checks++;
    if (fa !== 16'hFE00) begin
      fails++; $display("FAIL basic_first_we_addr: %h, required fe00", fa);
    end
    checks++;
    if (nw !== 160) begin
      fails++; $display("FAIL basic_write_count: %0d, required 160", nw);
    end
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== 8'(i)) bad++;
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL basic_oam_data: %0d bytes wrong, required 0", bad);
    end
    cpu_rd(16'hFF46, d, w);
    checks++;
    if (d !== 8'hC1) begin
      fails++; $display("FAIL basic_reg_read: %h, required c1", d);
    end
    $display("basic transfer: oam bad bytes %0d, ff46 reads %h", bad, d);
  endtask

  task automatic test_arbitration();
    int act, fw, nw, w;
    logic [15:0] fa;
    logic [7:0] d;
    cpu_wr(16'hFF46, 8'hC1, w);
    repeat (8) @(negedge clk);          // byte 1, phase 0
    cpu_addr = 16'hFF80; cpu_wdata = 8'h33; cpu_we = 1'b1;
    #1;
    checks++;
    if (cpu_wait !== 1'b1) begin
      fails++; $display("FAIL arb_stall_phase0: cpu_wait %b, required 1", cpu_wait);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 16'hC101) begin
      fails++; $display("FAIL arb_dma_read: re %b we %b addr %h, required re 1 we 0 addr c101",
                        mem_re, mem_we, mem_addr);
    end
    @(negedge clk);                      // phase 1
    #1;
    checks++;
    if (cpu_wait !== 1'b0) begin
      fails++; $display("FAIL arb_pass_phase1: cpu_wait %b, required 0", cpu_wait);
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'hFF80 || mem_wdata !== 8'h33) begin
      fails++; $display("FAIL arb_cpu_write: we %b addr %h data %h, required 1 ff80 33",
                        mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    cpu_rd(16'hFF80, d, w);
    checks++;
    if (d !== 8'h33) begin
      fails++; $display("FAIL arb_hram_read: %h, required 33", d);
    end
    $display("arbitration: hram write stalled then passed, read back %h", d);
    run_to_idle(act, fw, fa, nw);
  endtask

  task automatic test_lock();
    int act, fw, nw, w;
    logic [15:0] fa;
    mem[16'h8000] = 8'h77;
    mem[16'hC000] = 8'h5A;
    cpu_wr(16'hFF46, 8'hC1, w);
    repeat (9) @(negedge clk);          // byte 1, phase 1 (free)
    cpu_addr = 16'h8000; cpu_re = 1'b1;
    #1;
    checks++;
    if (cpu_wait !== 1'b0) begin
      fails++; $display("FAIL lock_read_wait: cpu_wait %b, required 0", cpu_wait);
    end
    checks++;
    if (mem_re !== !LOCK) begin
      fails++; $display("FAIL lock_read_strobe: mem_re %b, required %b", mem_re, !LOCK);
    end
    @(negedge clk);
    cpu_re = 1'b0;
    #1;
    checks++;
    if (cpu_rdata !== (LOCK ? 8'hFF : 8'h77)) begin
      fails++; $display("FAIL lock_read_data: %h, required %h", cpu_rdata, LOCK ? 8'hFF : 8'h77);
    end
    repeat (3) @(negedge clk);          // byte 2, phase 1
    cpu_addr = 16'hC000; cpu_wdata = 8'hAA; cpu_we = 1'b1;
    #1;
    checks++;
    if (mem_we !== !LOCK) begin
      fails++; $display("FAIL lock_write_strobe: mem_we %b, required %b", mem_we, !LOCK);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    run_to_idle(act, fw, fa, nw);
    checks++;
    if (mem[16'hC000] !== (LOCK ? 8'h5A : 8'hAA)) begin
      fails++; $display("FAIL lock_ram_after: mem[c000] %h, required %h",
                        mem[16'hC000], LOCK ? 8'h5A : 8'hAA);
    end
    $display("lock (enabled=%0d): c000 now %h", LOCK, mem[16'hC000]);
  endtask

  task automatic test_restart();
    int act, fw, nw, bad, w;
    logic [15:0] fa;
    logic [7:0] d;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC200 + i] = 8'(i * 3 + 7);
      mem[16'hFE00 + i] = 8'hEE;
    end
    cpu_wr(16'hFF46, 8'hC1, w);
    repeat (206) @(negedge clk);        // byte 50, phase 2
    cpu_addr = 16'hFF46; cpu_wdata = 8'hE2; cpu_we = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || cpu_wait !== 1'b0) begin
      fails++; $display("FAIL restart_drop_write: mem_we %b cpu_wait %b, required 0 0",
                        mem_we, cpu_wait);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    run_to_idle(act, fw, fa, nw);
    checks++;
    if (act !== 644) begin
      fails++; $display("FAIL restart_active_len: %0d cycles, required 644", act);
    end
    checks++;
    if (fw !== 6) begin
      fails++; $display("FAIL restart_first_we_cycle: cycle %0d, required 6", fw);
    end
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== 8'(i * 3 + 7)) bad++;
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL restart_oam_data: %0d bytes wrong, required 0", bad);
    end
    cpu_rd(16'hFF46, d, w);
    checks++;
    if (d !== 8'hE2) begin
      fails++; $display("FAIL restart_reg_read: %h, required e2", d);
    end
    $display("restart with e2: oam bad bytes %0d, ff46 reads %h", bad, d);
  endtask

  task automatic test_restart_final();
    int act, fw, nw, w;
    logic [15:0] fa;
    cpu_wr(16'hFF46, 8'hC1, w);
    repeat (642) @(negedge clk);        // byte 159, phase 2
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_we = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL restart_final_drop: mem_we %b, required 0", mem_we);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    run_to_idle(act, fw, fa, nw);
    checks++;
    if (act !== 644) begin
      fails++; $display("FAIL restart_final_len: %0d cycles, required 644", act);
    end
  endtask

  task automatic test_reset_mid();
    int nw, bad_lo, bad_hi, w;
    for (int i = 0; i < 160; i++) mem[16'hFE00 + i] = 8'hEE;
    cpu_wr(16'hFF46, 8'hC1, w);
    repeat (324) @(negedge clk);        // byte 80, phase 0
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (dma_active !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      fails++; $display("FAIL resetmid_strobes: active %b re %b we %b, required 000",
                        dma_active, mem_re, mem_we);
    end
    rst = 1'b0;
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (mem_we || dma_active) nw++;
    end
    checks++;
    if (nw !== 0) begin
      fails++; $display("FAIL resetmid_quiet: %0d active/write cycles after reset, required 0", nw);
    end
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < 80; i++) if (mem[16'hFE00 + i] !== 8'(i)) bad_lo++;
    for (int i = 80; i < 160; i++) if (mem[16'hFE00 + i] !== 8'hEE) bad_hi++;
    checks++;
    if (bad_lo !== 0) begin
      fails++; $display("FAIL resetmid_copied: %0d of bytes 0-79 wrong, required 0", bad_lo);
    end
    checks++;
    if (bad_hi !== 0) begin
      fails++; $display("FAIL resetmid_untouched: %0d of bytes 80-159 changed, required 0", bad_hi);
    end
    $display("reset mid-transfer: low bad %0d, high changed %0d", bad_lo, bad_hi);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_idle_regs();
    test_passthru();
    test_basic();
    test_arbitration();
    test_lock();
    test_restart();
    test_restart_final();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
